alu_share_arbiter: RTL

- Shares the single 32-bit ALU between two requesters: requester 0 is the core execute path, requester 1 is an auxiliary unit (address generation / debug).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Operands are latched at grant and driven to the external combinational ALU; the result and zero flag are registered and returned to the owner.
- MUL (opcode 4'b1000) is held on the ALU for a configurable number of cycles for timing relief.

---
 rtl/alu_share_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose
//   Lets two requesters share one external combinational 32-bit ALU.
//   Requester 0 is the core execute path. Requester 1 is the auxiliary unit
//   (address generation / debug). Operands are registered at grant and driven
//   to the ALU. The ALU result and zero flag are registered and returned to
//   the requester that owns the operation. The block does no arithmetic.
//
//   A MUL operation keeps its operands on the ALU for MUL_LATENCY cycles
//   before the result is captured. This gives the multiplier path timing
//   relief.
//
// Ports
//   clk, reset                     system clock; async active-high reset
//   reqN_valid_i / reqN_ready_o    request handshake, N = 0, 1
//   reqN_op_i, reqN_a_i, reqN_b_i  operation code and operands
//   rspN_valid_o / rspN_ready_i    response handshake, N = 0, 1
//   rsp_result_o, rsp_zero_o       shared registered response data;
//                                  qualified by rspN_valid_o
//   alu_op_o, alu_a_o, alu_b_o     registered drive to the external ALU
//   alu_result_i, alu_zero_i       outputs of the external ALU
//   busy_o                         high whenever the FSM is not idle
//
// Configuration
//   ALU_ARB_ROUND_ROBIN_EN  If defined, a tie goes to the requester that did
//                           not win the last grant. If undefined, requester 0
//                           always wins a tie, and no last-grant state exists.
//
// Parameters
//   MUL_LATENCY  Number of cycles the MUL operands are held on the ALU
//                before capture. Legal range is 1..15.
//   MUL_OPCODE   Operation code that selects the MUL hold.
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no operation in flight; arbitration open
//   EXEC    | operands on the ALU; counter runs down to capture
//   HOLD    | response registered and waiting for the owner to take it;
//           | arbitration reopens in the cycle the owner accepts
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int unsigned MUL_LATENCY = 2,
   parameter logic [3:0]  MUL_OPCODE  = 4'b1000
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [3:0]  req0_op_i,
   input  logic [31:0] req0_a_i,
   input  logic [31:0] req0_b_i,

   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [3:0]  req1_op_i,
   input  logic [31:0] req1_a_i,
   input  logic [31:0] req1_b_i,

   output logic        rsp0_valid_o,
   input  logic        rsp0_ready_i,
   output logic        rsp1_valid_o,
   input  logic        rsp1_ready_i,
   output logic [31:0] rsp_result_o,
   output logic        rsp_zero_o,

   output logic [3:0]  alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   input  logic [31:0] alu_result_i,
   input  logic        alu_zero_i,

   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // The counter is preloaded so that a value of zero marks the capture cycle.
   // A non-MUL operation therefore spends a single cycle in EXEC.
   localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  alu_op_q, alu_op_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_zero_q, rsp_zero_d;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;

   logic        owner_accept;
   logic        grant_en;
   logic        pick0, pick1;
   logic        hs0, hs1, hs_any;
   logic [3:0]  sel_op;
   logic [31:0] sel_a, sel_b;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   // The owner taking its response reopens the grant in the same cycle. This
   // lets a waiting request issue back-to-back with the accept.
   assign owner_accept = (state_q == ST_HOLD) &&
                         (owner_q ? rsp1_ready_i : rsp0_ready_i);
   assign grant_en     = (state_q == ST_IDLE) || owner_accept;

   // Each requester's pick depends only on the other requester's valid.
   // This keeps reqN_ready_o free of a combinational path from reqN_valid_i.
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   assign pick0 = !req1_valid_i ||  last_grant_q;
   assign pick1 = !req0_valid_i || !last_grant_q;

   assign last_grant_d = hs_any ? hs1 : last_grant_q;

   // Reset value 1 means requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   assign pick0 = 1'b1;
   assign pick1 = !req0_valid_i;
`endif

   assign req0_ready_o = grant_en && pick0;
   assign req1_ready_o = grant_en && pick1;

   assign hs0    = req0_valid_i && req0_ready_o;
   assign hs1    = req1_valid_i && req1_ready_o;
   assign hs_any = hs0 || hs1;

   // The picks never let both requesters handshake at once, so a plain select
   // on hs1 is enough here.
   assign sel_op = hs1 ? req1_op_i : req0_op_i;
   assign sel_a  = hs1 ? req1_a_i  : req0_a_i;
   assign sel_b  = hs1 ? req1_b_i  : req0_b_i;

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (hs_any) begin
               alu_op_d = sel_op;
               alu_a_d  = sel_a;
               alu_b_d  = sel_b;
               owner_d  = hs1;
               cnt_d    = (sel_op == MUL_OPCODE) ? MUL_CNT_INIT : 4'd0;
               state_d  = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               rsp_result_d = alu_result_i;
               rsp_zero_d   = alu_zero_i;
               rsp0_valid_d = !owner_q;
               rsp1_valid_d = owner_q;
               state_d      = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_HOLD: begin
            if (owner_accept) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               if (hs_any) begin
                  alu_op_d = sel_op;
                  alu_a_d  = sel_a;
                  alu_b_d  = sel_b;
                  owner_d  = hs1;
                  cnt_d    = (sel_op == MUL_OPCODE) ? MUL_CNT_INIT : 4'd0;
                  state_d  = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d      = ST_IDLE;
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         cnt_q        <= 4'd0;
         alu_op_q     <= 4'b0000;
         alu_a_q      <= 32'd0;
         alu_b_q      <= 32'd0;
         rsp_result_q <= 32'd0;
         rsp_zero_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
      end
   end

   assign alu_op_o     = alu_op_q;
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_zero_o   = rsp_zero_q;
   assign rsp0_valid_o = rsp0_valid_q;
   assign rsp1_valid_o = rsp1_valid_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule
